// File: rtl/ntt_scheduler.sv
// Radix-2 in-place NTT address sequencer: issues one coefficient pair per cycle and delays
// the pair addresses to the write-back port. Optional feature macro: NTT_SCHED_INVERSE_EN.
//  state   | meaning
//  S_IDLE  | waiting for start
//  S_RUN   | issuing pair k of stage s
//  S_DRAIN | flushing read + butterfly latency before the next stage
//  S_DONE  | one-cycle completion pulse
module ntt_scheduler #(
   parameter int LOGN   = 10,
   parameter int RD_LAT = 1,
   parameter int BF_LAT = 6
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_start,
`ifdef NTT_SCHED_INVERSE_EN
   input  logic            i_inverse,
   output logic [LOGN-1:0] o_omega_addr,
`else
   output logic [LOGN-2:0] o_omega_addr,
`endif
   input  logic            i_en,
   output logic [LOGN-1:0] o_rd_addr_a,
   output logic [LOGN-1:0] o_rd_addr_b,
   output logic            o_rd_en,
   output logic            o_bf_in_valid,
   output logic            o_bf_en,
   output logic [LOGN-1:0] o_wr_addr_a,
   output logic [LOGN-1:0] o_wr_addr_b,
   output logic            o_wr_en,
   output logic            o_busy,
   output logic            o_done
);
   localparam int D  = RD_LAT + BF_LAT;
   localparam int SW = $clog2(LOGN);
   localparam int CW = $clog2(D + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t          r_state, w_state_nxt;
   logic [SW-1:0]   r_s, w_s_nxt;
   logic [LOGN-2:0] r_k, w_k_nxt;
   logic [CW-1:0]   r_cnt, w_cnt_nxt;
   logic            r_inv, w_inv_nxt;

   logic            w_inv_req;
   logic            w_last_stage;
   logic [SW-1:0]   w_first_s;
   logic [SW-1:0]   w_s_step;
   logic            w_issue;

`ifdef NTT_SCHED_INVERSE_EN
   assign w_inv_req = i_inverse;
`else
   assign w_inv_req = 1'b0;
`endif

   assign w_first_s    = w_inv_req ? SW'(LOGN - 1) : '0;
   assign w_last_stage = r_inv ? (r_s == '0) : (r_s == SW'(LOGN - 1));
   assign w_s_step     = r_inv ? (r_s - SW'(1)) : (r_s + SW'(1));

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= S_IDLE;
         r_s     <= '0;
         r_k     <= '0;
         r_cnt   <= '0;
         r_inv   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_s     <= w_s_nxt;
         r_k     <= w_k_nxt;
         r_cnt   <= w_cnt_nxt;
         r_inv   <= w_inv_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_s_nxt     = r_s;
      w_k_nxt     = r_k;
      w_cnt_nxt   = r_cnt;
      w_inv_nxt   = r_inv;
      if (i_en) begin
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  w_state_nxt = S_RUN;
                  w_s_nxt     = w_first_s;
                  w_k_nxt     = '0;
                  w_inv_nxt   = w_inv_req;
               end
            end
            S_RUN: begin
               w_k_nxt = r_k + 1'b1;
               if (r_k == '1) begin
                  w_state_nxt = S_DRAIN;
                  w_k_nxt     = '0;
                  w_cnt_nxt   = CW'(D - 1);
               end
            end
            S_DRAIN: begin
               if (r_cnt == '0) begin
                  if (w_last_stage) begin
                     w_state_nxt = S_DONE;
                  end else begin
                     w_state_nxt = S_RUN;
                     w_s_nxt     = w_s_step;
                  end
               end else begin
                  w_cnt_nxt = r_cnt - 1'b1;
               end
            end
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   // pos and grp never exceed LOGN-1 bits, so the twiddle shift cannot overflow
   logic [LOGN-2:0] w_mask, w_pos, w_grp, w_om;
   logic [LOGN-1:0] w_half, w_a, w_b;

   always_comb begin
      w_mask = ~({(LOGN-1){1'b1}} << r_s);
      w_pos  = r_k & w_mask;
      w_grp  = r_k >> r_s;
      w_half = {{(LOGN-1){1'b0}}, 1'b1} << r_s;
      w_a    = ({1'b0, w_grp} << ({1'b0, r_s} + 1'b1)) | {1'b0, w_pos};
      w_b    = w_a + w_half;
      w_om   = w_pos << (SW'(LOGN - 1) - r_s);
   end

   assign w_issue     = (r_state == S_RUN);
   assign o_rd_en     = w_issue & i_en;
   assign o_rd_addr_a = w_issue ? w_a : '0;
   assign o_rd_addr_b = w_issue ? w_b : '0;
`ifdef NTT_SCHED_INVERSE_EN
   assign o_omega_addr = w_issue ? {r_inv, w_om} : '0;
`else
   assign o_omega_addr = w_issue ? w_om : '0;
`endif

   logic [LOGN-1:0] r_dly_a [D];
   logic [LOGN-1:0] r_dly_b [D];
   logic [D-1:0]    r_dly_v;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_dly_v <= '0;
         for (int i = 0; i < D; i++) begin
            r_dly_a[i] <= '0;
            r_dly_b[i] <= '0;
         end
      end else if (i_en) begin
         r_dly_v[0] <= w_issue;
         r_dly_a[0] <= o_rd_addr_a;
         r_dly_b[0] <= o_rd_addr_b;
         for (int i = 1; i < D; i++) begin
            r_dly_v[i] <= r_dly_v[i-1];
            r_dly_a[i] <= r_dly_a[i-1];
            r_dly_b[i] <= r_dly_b[i-1];
         end
      end
   end

   assign o_bf_in_valid = r_dly_v[RD_LAT-1] & i_en;
   assign o_bf_en       = i_en;
   assign o_wr_en       = r_dly_v[D-1] & i_en;
   assign o_wr_addr_a   = r_dly_a[D-1];
   assign o_wr_addr_b   = r_dly_b[D-1];
   assign o_busy        = (r_state == S_RUN) || (r_state == S_DRAIN);
   assign o_done        = (r_state == S_DONE) & i_en;

endmodule

// File: tb/tb_ntt_scheduler.sv
// Bench for ntt_scheduler at LOGN=3: reference pair sequence built from the transform's
// group/position structure, checked cycle by cycle with random enable stalls.
`timescale 1ns/1ps
module tb_ntt_scheduler;
   localparam int LOGN   = 3;
   localparam int RD_LAT = 1;
   localparam int BF_LAT = 6;
   localparam int N      = 1 << LOGN;
   localparam int D      = RD_LAT + BF_LAT;
   localparam int NS     = LOGN * (N/2 + D);
`ifdef NTT_SCHED_INVERSE_EN
   localparam int OW = LOGN;
`else
   localparam int OW = LOGN - 1;
`endif

   logic            clk = 1'b0;
   logic            reset, start, en;
`ifdef NTT_SCHED_INVERSE_EN
   logic            inverse;
`endif
   logic [LOGN-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
   logic [OW-1:0]   omega_addr;
   logic            rd_en, bf_in_valid, bf_en, wr_en, busy, done;

   typedef struct { int a; int b; int om; int s; } rd_t;
   typedef struct { int a; int b; int e; } wr_t;

   int  tests = 0;
   int  fails = 0;
   rd_t exp_q[$];

   ntt_scheduler #(.LOGN(LOGN), .RD_LAT(RD_LAT), .BF_LAT(BF_LAT)) dut (
      .i_clk(clk),
      .i_reset(reset),
      .i_start(start),
`ifdef NTT_SCHED_INVERSE_EN
      .i_inverse(inverse),
`endif
      .i_en(en),
      .o_rd_addr_a(rd_addr_a),
      .o_rd_addr_b(rd_addr_b),
      .o_rd_en(rd_en),
      .o_omega_addr(omega_addr),
      .o_bf_in_valid(bf_in_valid),
      .o_bf_en(bf_en),
      .o_wr_addr_a(wr_addr_a),
      .o_wr_addr_b(wr_addr_b),
      .o_wr_en(wr_en),
      .o_busy(busy),
      .o_done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Butterfly pairs of each stage: groups of 2*half elements, partner half away.
   task automatic build_model(input bit inv);
      int s, half;
      rd_t r;
      exp_q.delete();
      for (int t = 0; t < LOGN; t++) begin
         s    = inv ? (LOGN - 1 - t) : t;
         half = 1 << s;
         for (int base = 0; base < N; base += 2*half) begin
            for (int p = 0; p < half; p++) begin
               r.a  = base + p;
               r.b  = base + p + half;
               r.om = p * (N / (2*half)) + (inv ? N/2 : 0);
               r.s  = s;
               exp_q.push_back(r);
            end
         end
      end
   endtask

   // mode 0: en held high; 1: one stall of stall_len cycles after stall_at reads; 2: random en
   task automatic run_xform(input int mode, input int stall_at, input int stall_len,
                            input bit extra_starts, input bit inv);
      rd_t rq[$];
      wr_t wq[$];
      bit  rd_at[int];
      rd_t r;
      wr_t w;
      int  ecyc = 0, cyc = 0, first_cyc = -1, first_e = -1, nrd = 0, prev_s = -1;
      int  stall_left = 0;
      bit  stall_done = 0, got_done = 0;

      build_model(inv);
      rq = exp_q;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      start = 1'b1;
      en    = 1'b1;
`ifdef NTT_SCHED_INVERSE_EN
      inverse = inv;
`endif
      @(negedge clk);
      while (!got_done && cyc < 400) begin
         if (mode == 1 && !stall_done && nrd == stall_at) begin
            stall_left = stall_len;
            stall_done = 1'b1;
         end
         if (stall_left > 0) begin
            en = 1'b0;
            stall_left--;
         end else if (mode == 2) begin
            en = ($urandom_range(0, 3) != 0);
         end else begin
            en = 1'b1;
         end
         start = 1'b0;
         if (mode == 2 && $urandom_range(0, 9) == 0) start = 1'b1;
         if (extra_starts && (cyc == 5 || cyc == NS)) start = 1'b1;
         #1;
         chk("bf_en", bf_en, en);
         if (!en) begin
            chk("stall_strobes", {rd_en, bf_in_valid, wr_en}, 0);
         end else begin
            chk("bf_in_valid", bf_in_valid, rd_at.exists(ecyc - RD_LAT));
            chk("wr_en", wr_en, rd_at.exists(ecyc - D));
            if (wr_en && wq.size() > 0) begin
               w = wq.pop_front();
               chk("wr_addr_a", wr_addr_a, w.a);
               chk("wr_addr_b", wr_addr_b, w.b);
               chk("wr_latency", ecyc - w.e, D);
            end
            if (rd_en) begin
               if (rq.size() > 0) begin
                  r = rq.pop_front();
                  if (prev_s >= 0 && r.s != prev_s) chk("raw_pending_writes", wq.size(), 0);
                  prev_s = r.s;
                  chk("rd_addr_a", rd_addr_a, r.a);
                  chk("rd_addr_b", rd_addr_b, r.b);
                  chk("omega_addr", omega_addr, r.om);
                  wq.push_back(wr_t'{a: r.a, b: r.b, e: ecyc});
                  rd_at[ecyc] = 1'b1;
                  if (first_cyc < 0) begin
                     first_cyc = cyc;
                     first_e   = ecyc;
                  end
                  nrd++;
               end else begin
                  chk("rd_extra", rd_en, 0);
               end
            end
         end
         if (done) begin
            got_done = 1'b1;
            chk("done_latency_enabled", ecyc - first_e, NS);
            chk("reads_left", rq.size(), 0);
            chk("busy_at_done", busy, 0);
            if (mode != 2) begin
               chk("first_rd_cycle", first_cyc, 0);
               chk("done_latency_wall", cyc - first_cyc, NS + ((mode == 1) ? stall_len : 0));
            end
         end else if (rq.size() > 0 || wq.size() > 0) begin
            chk("busy", busy, 1);
         end
         if (en) ecyc++;
         cyc++;
         @(negedge clk);
      end
      if (!got_done) chk("done_seen", got_done, 1);
      for (int i = 0; i < 3; i++) begin
         start = 1'b0;
         en    = 1'b1;
         #1;
         chk("idle_after_done", {rd_en, wr_en, busy, done}, 0);
         @(negedge clk);
      end
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      en    = 1'b1;
`ifdef NTT_SCHED_INVERSE_EN
      inverse = 1'b0;
`endif
      @(negedge clk);
      chk("reset_strobes", {rd_en, bf_in_valid, wr_en, busy, done}, 0);
      chk("reset_addrs", {rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b}, 0);
      chk("reset_omega", omega_addr, 0);
      chk("reset_bf_en_hi", bf_en, 1);
      en = 1'b0;
      #1;
      chk("reset_bf_en_lo", bf_en, 0);
      en = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      run_xform(0, 0, 0, 1'b1, 1'b0);
      run_xform(1, 6, 5, 1'b0, 1'b0);

      // reset in the middle of stage-0 drain, with writes still in flight
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      #1;
      chk("busy_before_reset", busy, 1);
      reset = 1'b1;
      #1;
      chk("midrun_reset_strobes", {rd_en, bf_in_valid, wr_en, busy, done}, 0);
      chk("midrun_reset_addrs", {rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b}, 0);
      chk("midrun_reset_omega", omega_addr, 0);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 12; i++) begin
         #1;
         chk("post_reset_quiet", {rd_en, bf_in_valid, wr_en, busy}, 0);
         @(negedge clk);
      end

      run_xform(0, 0, 0, 1'b0, 1'b0);
      run_xform(2, 0, 0, 1'b0, 1'b0);
      run_xform(2, 0, 0, 1'b0, 1'b0);
`ifdef NTT_SCHED_INVERSE_EN
      run_xform(0, 0, 0, 1'b0, 1'b1);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
